// File: rtl/pipelined_cpu.sv
// pipelined_cpu
//   Five-stage (IF/ID/EX/MEM/WB) pipelined 32-bit MIPS-subset core with
//   instruction ROM, register file, ALU, data RAM, forwarding and hazard logic.
//   IMEM has no write port. Its image comes from the program loader, which is a
//   binary image preload in the build flow or a hierarchical load from a bench.
// Ports
//   CLOCK  in  1  system clock; all state updates on the rising edge
//   RESET  in  1  synchronous active-high reset; clears PC and pipeline registers only
// Parameters
//   IMEM_WORDS  instruction ROM depth in 32-bit words
//   DMEM_WORDS  data RAM depth in 32-bit words (index = address >> 2)

// Register file: 32 x 32, two combinational read ports.
// Writes happen on the falling edge so the WB result is readable in ID within the same cycle.
module RegisterFile (
  input  logic        clock,
  input  logic        writeEnable,
  input  logic [4:0]  writeAddr,
  input  logic [31:0] writeData,
  input  logic [4:0]  readAddr1,
  input  logic [4:0]  readAddr2,
  output logic [31:0] readData1,
  output logic [31:0] readData2
);
  logic [31:0] RegFile [0:31];

  // $0 is never written; reads of $0 are forced to zero below
  always_ff @(negedge clock) begin
    if (writeEnable && writeAddr != 5'd0) RegFile[writeAddr] <= writeData;
  end

  assign readData1 = (readAddr1 == 5'd0) ? 32'd0 : RegFile[readAddr1];
  assign readData2 = (readAddr2 == 5'd0) ? 32'd0 : RegFile[readAddr2];
endmodule

// Data RAM: combinational read, rising-edge write, word indexed
module MainMemory #(
  parameter int WORDS = 512,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          writeEnable,
  input  logic [AW-1:0] index,
  input  logic [31:0]   writeData,
  output logic [31:0]   readData
);
  logic [31:0] DATA_RAM [0:WORDS-1];

  always_ff @(posedge clock) begin
    if (writeEnable) DATA_RAM[index] <= writeData;
  end

  assign readData = DATA_RAM[index];
endmodule

module pipelined_cpu #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 512
) (
  input  logic CLOCK,
  input  logic RESET
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LW = 6'h23,
                         OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_ADD = 6'h20,
                         F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  } aluOp_t;

  logic [31:0] IMEM [0:IMEM_WORDS-1];

  // ---------------- IF ----------------
  logic [31:0] PC, PCPlus4_F, Inst_F, PCJumped, jumpTarget_F;
  logic        jump_F;
  // ---------------- ID ----------------
  logic [31:0] Inst_D, PCPlus4_D, rsData_D, rtData_D, imm_D, brA_D, brB_D, redirectTarget_D;
  logic [5:0]  op_D, funct_D;
  logic [4:0]  rs_D, rt_D, rd_D, shamt_D, regAddr3_D;
  logic        regWrite_D, memToReg_D, memWrite_D, aluSrc_D, shiftVar_D, link_D, zeroExt_D;
  logic        isBeq_D, isBne_D, isJr_D, branchTaken_D, redirect_D;
  logic        loadUse, branchStall, stall;
  aluOp_t      aluCtrl_D;
  // ---------------- EX ----------------
  logic        RegWriteEN_E, Mem2RegSEL_E, MemWriteEN_E, ALUSrc_E, ShiftVar_E, Link_E, ZeroFlag_E;
  aluOp_t      ALUCtrl_E;
  logic [31:0] RsData_E, RtData_E, Imm_E, PCPlus4_E, Op1_E, Op2_E, fwdB_E, aluResult_E, ALUOut_E;
  logic [4:0]  Rs_E, Rt_E, Shamt_E, RegAddr3_E, shiftAmt_E;
  // ---------------- MEM / WB ----------------
  logic        RegWriteEN_M, Mem2RegSEL_M, MemWriteEN_M, RegWriteEN_W, Mem2RegSEL_W;
  logic [31:0] ALUOut_M, WriteData_M, MemReadData_M, ALUOut_W, MemReadData_W, RegWriteData_W;
  logic [4:0]  RegAddr3_M, RegAddr3_W;

  // Instruction fetch; j/jal resolve here so they need no flush.
  // An ID redirect outranks an IF jump because the fetched word is then on the wrong path.
  assign Inst_F       = IMEM[PC[IAW+1:2]];
  assign PCPlus4_F    = PC + 32'd4;
  assign jump_F       = (Inst_F[31:26] == OP_J) || (Inst_F[31:26] == OP_JAL);
  assign jumpTarget_F = {PCPlus4_F[31:28], Inst_F[25:0], 2'b00};
  assign PCJumped     = redirect_D ? redirectTarget_D : (jump_F ? jumpTarget_F : PCPlus4_F);

  // PC holds during a stall
  always_ff @(posedge CLOCK) begin
    if (RESET)       PC <= 32'd0;
    else if (!stall) PC <= PCJumped;
  end

  // IF/ID: flushed to NOP by a taken branch or jr, frozen during a stall
  always_ff @(posedge CLOCK) begin
    if (RESET || redirect_D) begin
      Inst_D    <= 32'd0;
      PCPlus4_D <= 32'd0;
    end else if (!stall) begin
      Inst_D    <= Inst_F;
      PCPlus4_D <= PCPlus4_F;
    end
  end

  assign op_D    = Inst_D[31:26];
  assign rs_D    = Inst_D[25:21];
  assign rt_D    = Inst_D[20:16];
  assign rd_D    = Inst_D[15:11];
  assign shamt_D = Inst_D[10:6];
  assign funct_D = Inst_D[5:0];

  // Main decoder; anything not recognised leaves every control at zero (NOP)
  always_comb begin
    regWrite_D = 1'b0; memToReg_D = 1'b0; memWrite_D = 1'b0; aluSrc_D = 1'b0;
    shiftVar_D = 1'b0; link_D = 1'b0; zeroExt_D = 1'b0;
    isBeq_D = 1'b0; isBne_D = 1'b0; isJr_D = 1'b0;
    aluCtrl_D = ALU_ADD; regAddr3_D = rd_D;
    case (op_D)
      OP_RTYPE: begin
        regWrite_D = 1'b1;
        case (funct_D)
          F_SLL:         aluCtrl_D = ALU_SLL;
          F_SRL:         aluCtrl_D = ALU_SRL;
          F_SRA:         aluCtrl_D = ALU_SRA;
          F_SLLV:        begin aluCtrl_D = ALU_SLL; shiftVar_D = 1'b1; end
          F_SRLV:        begin aluCtrl_D = ALU_SRL; shiftVar_D = 1'b1; end
          F_SRAV:        begin aluCtrl_D = ALU_SRA; shiftVar_D = 1'b1; end
          F_ADD, F_ADDU: aluCtrl_D = ALU_ADD;
          F_SUB, F_SUBU: aluCtrl_D = ALU_SUB;
          F_AND:         aluCtrl_D = ALU_AND;
          F_OR:          aluCtrl_D = ALU_OR;
          F_XOR:         aluCtrl_D = ALU_XOR;
          F_NOR:         aluCtrl_D = ALU_NOR;
          F_SLT:         aluCtrl_D = ALU_SLT;
          F_JR:          begin regWrite_D = 1'b0; isJr_D = 1'b1; end
          default:       regWrite_D = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin regWrite_D = 1'b1; aluSrc_D = 1'b1; regAddr3_D = rt_D; end
      OP_SLTI: begin regWrite_D = 1'b1; aluSrc_D = 1'b1; regAddr3_D = rt_D; aluCtrl_D = ALU_SLT; end
      OP_ANDI: begin regWrite_D = 1'b1; aluSrc_D = 1'b1; regAddr3_D = rt_D; aluCtrl_D = ALU_AND; zeroExt_D = 1'b1; end
      OP_ORI:  begin regWrite_D = 1'b1; aluSrc_D = 1'b1; regAddr3_D = rt_D; aluCtrl_D = ALU_OR;  zeroExt_D = 1'b1; end
      OP_XORI: begin regWrite_D = 1'b1; aluSrc_D = 1'b1; regAddr3_D = rt_D; aluCtrl_D = ALU_XOR; zeroExt_D = 1'b1; end
      OP_LW:   begin regWrite_D = 1'b1; memToReg_D = 1'b1; aluSrc_D = 1'b1; regAddr3_D = rt_D; end
      OP_SW:   begin memWrite_D = 1'b1; aluSrc_D = 1'b1; end
      OP_BEQ:  isBeq_D = 1'b1;
      OP_BNE:  isBne_D = 1'b1;
      OP_JAL:  begin regWrite_D = 1'b1; link_D = 1'b1; regAddr3_D = 5'd31; end
      default: ;
    endcase
  end

  assign imm_D = zeroExt_D ? {16'd0, Inst_D[15:0]} : {{16{Inst_D[15]}}, Inst_D[15:0]};

  RegisterFile register_file (
    .clock(CLOCK), .writeEnable(RegWriteEN_W), .writeAddr(RegAddr3_W), .writeData(RegWriteData_W),
    .readAddr1(rs_D), .readAddr2(rt_D), .readData1(rsData_D), .readData2(rtData_D)
  );

  // Branch/jr operands: only a non-load in MEM can be forwarded; other producers stall below
  assign brA_D = (RegWriteEN_M && RegAddr3_M == rs_D && rs_D != 5'd0) ? ALUOut_M : rsData_D;
  assign brB_D = (RegWriteEN_M && RegAddr3_M == rt_D && rt_D != 5'd0) ? ALUOut_M : rtData_D;
  assign branchTaken_D    = (isBeq_D && brA_D == brB_D) || (isBne_D && brA_D != brB_D);
  assign redirectTarget_D = isJr_D ? brA_D : PCPlus4_D + {imm_D[29:0], 2'b00};
  assign redirect_D       = (branchTaken_D || isJr_D) && !stall;

  // Load-use compares both source fields whether or not the ID instruction reads them
  assign loadUse = Mem2RegSEL_E && RegAddr3_E != 5'd0 &&
                   (RegAddr3_E == rs_D || RegAddr3_E == rt_D);
  assign branchStall =
      ((isBeq_D || isBne_D || isJr_D) && rs_D != 5'd0 &&
       ((RegWriteEN_E && RegAddr3_E == rs_D) ||
        (RegWriteEN_M && Mem2RegSEL_M && RegAddr3_M == rs_D))) ||
      ((isBeq_D || isBne_D) && rt_D != 5'd0 &&
       ((RegWriteEN_E && RegAddr3_E == rt_D) ||
        (RegWriteEN_M && Mem2RegSEL_M && RegAddr3_M == rt_D)));
  assign stall = loadUse || branchStall;

  // ID/EX: a stall turns this slot into a bubble
  always_ff @(posedge CLOCK) begin
    if (RESET || stall) begin
      RegWriteEN_E <= 1'b0; Mem2RegSEL_E <= 1'b0; MemWriteEN_E <= 1'b0; ALUSrc_E <= 1'b0;
      ShiftVar_E <= 1'b0; Link_E <= 1'b0; ALUCtrl_E <= ALU_ADD;
      RsData_E <= 32'd0; RtData_E <= 32'd0; Imm_E <= 32'd0; PCPlus4_E <= 32'd0;
      Rs_E <= 5'd0; Rt_E <= 5'd0; Shamt_E <= 5'd0; RegAddr3_E <= 5'd0;
    end else begin
      RegWriteEN_E <= regWrite_D; Mem2RegSEL_E <= memToReg_D; MemWriteEN_E <= memWrite_D;
      ALUSrc_E <= aluSrc_D; ShiftVar_E <= shiftVar_D; Link_E <= link_D; ALUCtrl_E <= aluCtrl_D;
      RsData_E <= rsData_D; RtData_E <= rtData_D; Imm_E <= imm_D; PCPlus4_E <= PCPlus4_D;
      Rs_E <= rs_D; Rt_E <= rt_D; Shamt_E <= shamt_D; RegAddr3_E <= regAddr3_D;
    end
  end

  // Operand forwarding, MEM result preferred over WB result
  always_comb begin
    Op1_E = RsData_E;
    if (RegWriteEN_M && RegAddr3_M == Rs_E && Rs_E != 5'd0)      Op1_E = ALUOut_M;
    else if (RegWriteEN_W && RegAddr3_W == Rs_E && Rs_E != 5'd0) Op1_E = RegWriteData_W;
    fwdB_E = RtData_E;
    if (RegWriteEN_M && RegAddr3_M == Rt_E && Rt_E != 5'd0)      fwdB_E = ALUOut_M;
    else if (RegWriteEN_W && RegAddr3_W == Rt_E && Rt_E != 5'd0) fwdB_E = RegWriteData_W;
  end

  assign Op2_E      = ALUSrc_E ? Imm_E : fwdB_E;
  assign shiftAmt_E = ShiftVar_E ? Op1_E[4:0] : Shamt_E;

  // ALU; shifts act on the rt operand (Op2, since shifts never select the immediate)
  always_comb begin
    aluResult_E = 32'd0;
    case (ALUCtrl_E)
      ALU_ADD: aluResult_E = Op1_E + Op2_E;
      ALU_SUB: aluResult_E = Op1_E - Op2_E;
      ALU_AND: aluResult_E = Op1_E & Op2_E;
      ALU_OR:  aluResult_E = Op1_E | Op2_E;
      ALU_XOR: aluResult_E = Op1_E ^ Op2_E;
      ALU_NOR: aluResult_E = ~(Op1_E | Op2_E);
      ALU_SLT: aluResult_E = ($signed(Op1_E) < $signed(Op2_E)) ? 32'd1 : 32'd0;
      ALU_SLL: aluResult_E = Op2_E << shiftAmt_E;
      ALU_SRL: aluResult_E = Op2_E >> shiftAmt_E;
      ALU_SRA: aluResult_E = $unsigned($signed(Op2_E) >>> shiftAmt_E);
      default: aluResult_E = 32'd0;
    endcase
  end

  // jal carries its link address down the ALU result path
  assign ALUOut_E   = Link_E ? PCPlus4_E : aluResult_E;
  assign ZeroFlag_E = (ALUOut_E == 32'd0);

  logic unusedZeroFlag;
  assign unusedZeroFlag = ZeroFlag_E;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      RegWriteEN_M <= 1'b0; Mem2RegSEL_M <= 1'b0; MemWriteEN_M <= 1'b0;
      ALUOut_M <= 32'd0; WriteData_M <= 32'd0; RegAddr3_M <= 5'd0;
    end else begin
      RegWriteEN_M <= RegWriteEN_E; Mem2RegSEL_M <= Mem2RegSEL_E; MemWriteEN_M <= MemWriteEN_E;
      ALUOut_M <= ALUOut_E; WriteData_M <= fwdB_E; RegAddr3_M <= RegAddr3_E;
    end
  end

  MainMemory #(.WORDS(DMEM_WORDS)) mainmemory (
    .clock(CLOCK), .writeEnable(MemWriteEN_M), .index(ALUOut_M[DAW+1:2]),
    .writeData(WriteData_M), .readData(MemReadData_M)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      RegWriteEN_W <= 1'b0; Mem2RegSEL_W <= 1'b0; ALUOut_W <= 32'd0;
      MemReadData_W <= 32'd0; RegAddr3_W <= 5'd0;
    end else begin
      RegWriteEN_W <= RegWriteEN_M; Mem2RegSEL_W <= Mem2RegSEL_M; ALUOut_W <= ALUOut_M;
      MemReadData_W <= MemReadData_M; RegAddr3_W <= RegAddr3_M;
    end
  end

  assign RegWriteData_W = Mem2RegSEL_W ? MemReadData_W : ALUOut_W;
endmodule

// File: tb/tb_pipelined_cpu.sv
// tb_pipelined_cpu
//   Directed programs loaded into the core's instruction ROM; architectural state
//   (registers, data RAM, PC, pipeline controls) is inspected hierarchically.
module tb_pipelined_cpu;
  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SRLV = 6'h06,
                         F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_NOR = 6'h27, F_SLT = 6'h2A;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   stallCount = 0;
  logic [31:0] prog [$];

  pipelined_cpu dut (.CLOCK(CLOCK), .RESET(RESET));

  always #5 CLOCK = ~CLOCK;

  // Count stall cycles outside reset
  always @(negedge CLOCK) begin
    if (!RESET && dut.stall) stallCount = stallCount + 1;
  end

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {6'd0, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jType(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

  function automatic logic [31:0] reg32(input int n);
    return dut.register_file.RegFile[n];
  endfunction

  // Clear the ROM to NOPs and copy the current program in from word 0
  task automatic loadProgram();
    for (int i = 0; i < 512; i++) dut.IMEM[i] = 32'd0;
    for (int i = 0; i < prog.size(); i++) dut.IMEM[i] = prog[i];
  endtask

  // Hold reset for the given number of rising edges, release just after the last
  task automatic applyStimulus(input int resetEdges);
    RESET = 1'b1;
    repeat (resetEdges) @(posedge CLOCK);
    #1 RESET = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    // Test 1: back-to-back forwarding
    prog = {iType(OP_ADDI, 5'd0, 5'd1, 16'd5),
            iType(OP_ADDI, 5'd0, 5'd2, 16'hFFFD),
            rType(5'd1, 5'd2, 5'd3, 5'd0, F_ADD),
            jType(OP_J, 26'd3)};
    loadProgram();
    applyStimulus(2);
    $display("[TB] test 1: forwarding");
    checkOutput("reset_pc", dut.PC, 32'd0);
    checkOutput("reset_inst_d", dut.Inst_D, 32'd0);
    runCycles(15);
    checkOutput("t1_r1", reg32(1), 32'd5);
    checkOutput("t1_r2", reg32(2), 32'hFFFF_FFFD);
    checkOutput("t1_r3", reg32(3), 32'd2);

    // Test 2: store, load, load-use stall
    prog = {iType(OP_ADDI, 5'd0, 5'd1, 16'd12),
            iType(OP_SW, 5'd0, 5'd1, 16'd8),
            iType(OP_LW, 5'd0, 5'd4, 16'd8),
            rType(5'd4, 5'd4, 5'd5, 5'd0, F_ADD),
            jType(OP_J, 26'd4)};
    loadProgram();
    applyStimulus(1);
    stallCount = 0;
    $display("[TB] test 2: load/store");
    runCycles(20);
    checkOutput("t2_ram2", dut.mainmemory.DATA_RAM[2], 32'd12);
    checkOutput("t2_r4", reg32(4), 32'd12);
    checkOutput("t2_r5", reg32(5), 32'd24);
    checkOutput("t2_stalls", 32'(stallCount), 32'd1);

    // Test 3: taken branch flushes the next instruction
    prog = {iType(OP_ADDI, 5'd0, 5'd1, 16'd1),
            iType(OP_BEQ, 5'd1, 5'd1, 16'd1),
            iType(OP_ADDI, 5'd0, 5'd6, 16'd9),
            iType(OP_ADDI, 5'd0, 5'd7, 16'd7),
            jType(OP_J, 26'd4)};
    loadProgram();
    applyStimulus(1);
    $display("[TB] test 3: branch");
    runCycles(20);
    checkOutput("t3_r6", reg32(6), 32'd0);
    checkOutput("t3_r7", reg32(7), 32'd7);

    // Test 4: jal / jr
    prog = {iType(OP_ADDI, 5'd0, 5'd10, 16'd1),
            iType(OP_ADDI, 5'd0, 5'd11, 16'd2),
            jType(OP_JAL, 26'd10),
            iType(OP_ADDI, 5'd0, 5'd12, 16'd3),
            jType(OP_J, 26'd4),
            32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
            iType(OP_ADDI, 5'd0, 5'd13, 16'd4),
            rType(5'd31, 5'd0, 5'd0, 5'd0, F_JR),
            iType(OP_ADDI, 5'd0, 5'd14, 16'd5)};
    loadProgram();
    applyStimulus(1);
    $display("[TB] test 4: jal/jr");
    checkOutput("t4_reset_pc", dut.PC, 32'd0);
    runCycles(3);
    checkOutput("t4_pc_after_jal", dut.PC, 32'd40);
    runCycles(20);
    checkOutput("t4_r31", reg32(31), 32'd12);
    checkOutput("t4_r13", reg32(13), 32'd4);
    checkOutput("t4_r14", reg32(14), 32'd0);
    checkOutput("t4_r12", reg32(12), 32'd3);

    // Test 5: shifts, slt, nor, ori, sub
    prog = {iType(OP_ADDI, 5'd0, 5'd1, 16'd1),
            rType(5'd0, 5'd1, 5'd8, 5'd4, F_SLL),
            rType(5'd0, 5'd1, 5'd15, 5'd31, F_SLL),
            rType(5'd0, 5'd15, 5'd16, 5'd31, F_SRA),
            iType(OP_ADDI, 5'd0, 5'd17, 16'hFFFF),
            rType(5'd17, 5'd1, 5'd18, 5'd0, F_SLT),
            rType(5'd1, 5'd15, 5'd19, 5'd0, F_SRLV),
            rType(5'd0, 5'd0, 5'd20, 5'd0, F_NOR),
            iType(OP_ORI, 5'd0, 5'd21, 16'h8001),
            rType(5'd1, 5'd17, 5'd22, 5'd0, F_SUB),
            rType(5'd0, 5'd15, 5'd25, 5'd31, F_SRL),
            jType(OP_J, 26'd11)};
    loadProgram();
    applyStimulus(1);
    $display("[TB] test 5: alu");
    runCycles(25);
    checkOutput("t5_sll", reg32(8), 32'd16);
    checkOutput("t5_sll31", reg32(15), 32'h8000_0000);
    checkOutput("t5_sra", reg32(16), 32'hFFFF_FFFF);
    checkOutput("t5_slt", reg32(18), 32'd1);
    checkOutput("t5_srlv", reg32(19), 32'h4000_0000);
    checkOutput("t5_nor", reg32(20), 32'hFFFF_FFFF);
    checkOutput("t5_ori", reg32(21), 32'h0000_8001);
    checkOutput("t5_sub", reg32(22), 32'd2);
    checkOutput("t5_srl", reg32(25), 32'd1);

    // Test 6: reset mid-program keeps registers and data RAM
    prog = {iType(OP_ADDI, 5'd0, 5'd23, 16'd100),
            iType(OP_SW, 5'd0, 5'd23, 16'd16),
            iType(OP_ADDI, 5'd24, 5'd24, 16'd1),
            jType(OP_J, 26'd2)};
    loadProgram();
    applyStimulus(1);
    $display("[TB] test 6: mid-program reset");
    runCycles(12);
    applyStimulus(2);
    checkOutput("t6_pc", dut.PC, 32'd0);
    checkOutput("t6_inst_d", dut.Inst_D, 32'd0);
    checkOutput("t6_regwrite_e", 32'(dut.RegWriteEN_E), 32'd0);
    checkOutput("t6_memwrite_m", 32'(dut.MemWriteEN_M), 32'd0);
    checkOutput("t6_regwrite_w", 32'(dut.RegWriteEN_W), 32'd0);
    checkOutput("t6_r23", reg32(23), 32'd100);
    checkOutput("t6_ram4", dut.mainmemory.DATA_RAM[4], 32'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
